// File: rtl/input_capture_pkg.sv
// ---------------------------------------------------------------------------
// input_pkg
//   Shared definitions for the input capture slice: FSM state encoding,
//   1-bit ON/OFF constants and the default switch-bank width.
//   (Package only; no ports.)
// ---------------------------------------------------------------------------
package input_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        RELEASE
    } state_t;

    localparam logic ON  = 1'b1;
    localparam logic OFF = 1'b0;

    localparam int DEFAULT_WORD_SIZE = 8;

endpackage

// File: rtl/input_capture_if.sv
// ---------------------------------------------------------------------------
// input_capture_if
//   Bundles the raw user inputs and the conditioned store/sequence outputs.
//   Signals:
//     button_raw     raw, asynchronous, bouncy store button
//     switches_raw   raw, asynchronous switch bank (WORD_SIZE bits)
//     store          store request, high for the hold window
//     sequence_word  captured switch value ("sequence" is a reserved word)
//     busy           capture FSM is not idle
//     reject         one-cycle pulse for a press with an all-zero value
//   Modports:
//     master  the capture block (drives store/sequence_word/busy/reject)
//     slave   the user side / store stage (drives the raw inputs)
// ---------------------------------------------------------------------------
interface input_capture_if #(
    parameter int WORD_SIZE = input_pkg::DEFAULT_WORD_SIZE
);
    logic                 button_raw;
    logic [WORD_SIZE-1:0] switches_raw;
    logic                 store;
    logic [WORD_SIZE-1:0] sequence_word;
    logic                 busy;
    logic                 reject;

    modport master (
        input  button_raw,
        input  switches_raw,
        output store,
        output sequence_word,
        output busy,
        output reject
    );

    modport slave (
        output button_raw,
        output switches_raw,
        input  store,
        input  sequence_word,
        input  busy,
        input  reject
    );
endinterface

// File: rtl/input_capture_debounce.sv
// ---------------------------------------------------------------------------
// debounce
//   Synchronizes one raw asynchronous input through SYNC_STAGES flops and
//   debounces it: the clean output only toggles after DEBOUNCE_CYCLES
//   consecutive synchronized samples that differ from it.
//   Ports:
//     slow_clock  in   sampling clock
//     reset       in   asynchronous, active-high
//     raw         in   raw asynchronous input
//     clean       out  synchronized, debounced level
// ---------------------------------------------------------------------------
module debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic slow_clock,
    input  logic reset,
    input  logic raw,
    output logic clean
);
    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_chain;
    logic                   synced;
    logic [CNT_W-1:0]       count;

    assign synced = sync_chain[SYNC_STAGES-1];

    always_ff @(posedge slow_clock or posedge reset) begin
        if (reset) begin
            sync_chain <= '0;
            count      <= '0;
            clean      <= 1'b0;
        end else begin
            sync_chain <= {sync_chain[SYNC_STAGES-2:0], raw};
            // Any sample agreeing with the current level restarts the run,
            // so a glitch shorter than DEBOUNCE_CYCLES never gets through.
            if (synced == clean) begin
                count <= '0;
            end else if (count == CNT_LAST) begin
                clean <= ~clean;
                count <= '0;
            end else begin
                count <= count + CNT_W'(1);
            end
        end
    end
endmodule

// File: rtl/input_capture.sv
// ---------------------------------------------------------------------------
// input_capture
//   Turns a bouncy store button and a raw switch bank into a clean
//   store/sequence pair. A debounced press in IDLE samples the synchronized
//   switches; a non-zero value is driven on sequence_word with store held
//   high for STORE_HOLD cycles, a zero value is refused with a reject pulse.
//   The FSM then waits for the button to be released before re-arming.
//   Ports:
//     slow_clock  in   sampling clock for all logic
//     reset       in   asynchronous, active-high
//     bus         input_capture_if.master (button_raw, switches_raw in;
//                 store, sequence_word, busy, reject out)
// ---------------------------------------------------------------------------
module input_capture
    import input_pkg::*;
#(
    parameter int WORD_SIZE       = DEFAULT_WORD_SIZE,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int STORE_HOLD      = 12
) (
    input  logic             slow_clock,
    input  logic             reset,
    input_capture_if.master  bus
);
    localparam int                HOLD_W    = $clog2(STORE_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(STORE_HOLD - 1);

    logic [WORD_SIZE-1:0] switch_sync [SYNC_STAGES];
    logic [WORD_SIZE-1:0] switches_synced;
    logic                 btn_db;
    logic                 btn_db_q;
    logic                 press;
    logic [HOLD_W-1:0]    hold_count;
    state_t               state;

    debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_button (
        .slow_clock (slow_clock),
        .reset      (reset),
        .raw        (bus.button_raw),
        .clean      (btn_db)
    );

    // Switch bits are synchronized individually; they are only sampled well
    // after the button has settled, so bit skew across the bank is harmless.
    always_ff @(posedge slow_clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) switch_sync[i] <= '0;
        end else begin
            switch_sync[0] <= bus.switches_raw;
            for (int i = 1; i < SYNC_STAGES; i++) switch_sync[i] <= switch_sync[i-1];
        end
    end

    assign switches_synced = switch_sync[SYNC_STAGES-1];
    assign press           = btn_db & ~btn_db_q;

    // Outputs are set together with the state they belong to, so store and
    // busy are registered copies of (state == HOLD) and (state != IDLE).
    always_ff @(posedge slow_clock or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            hold_count        <= '0;
            btn_db_q          <= OFF;
            bus.store         <= OFF;
            bus.sequence_word <= '0;
            bus.busy          <= OFF;
            bus.reject        <= OFF;
        end else begin
            btn_db_q   <= btn_db;
            bus.reject <= OFF;
            case (state)
                IDLE: begin
                    if (press) begin
                        bus.busy <= ON;
                        if (switches_synced != '0) begin
                            state             <= HOLD;
                            bus.store         <= ON;
                            bus.sequence_word <= switches_synced;
                            hold_count        <= HOLD_LAST;
                        end else begin
                            // Zero is never issued; the old sequence stays.
                            state      <= RELEASE;
                            bus.reject <= ON;
                        end
                    end
                end
                HOLD: begin
                    if (hold_count == '0) begin
                        state     <= RELEASE;
                        bus.store <= OFF;
                    end else begin
                        hold_count <= hold_count - HOLD_W'(1);
                    end
                end
                RELEASE: begin
                    // Requiring a release stops a held button re-triggering.
                    if (btn_db == OFF) begin
                        state    <= IDLE;
                        bus.busy <= OFF;
                    end
                end
                default: begin
                    state     <= IDLE;
                    bus.store <= OFF;
                    bus.busy  <= OFF;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_input_capture.sv
// ---------------------------------------------------------------------------
// tb_input_capture
//   Directed bench for input_capture at default parameters. All actions and
//   samples happen 1 time unit after a rising slow_clock edge; edge counts in
//   the comments are relative to the step that raised the button.
// ---------------------------------------------------------------------------
module tb_input_capture;
    logic slow_clock;
    logic reset;

    int checks   = 0;
    int failures = 0;
    int store_cnt  = 0;
    int reject_cnt = 0;
    int store_snap;
    int reject_snap;

    input_capture_if #(.WORD_SIZE(8)) bus ();

    input_capture #(
        .WORD_SIZE       (8),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .STORE_HOLD      (12)
    ) dut (
        .slow_clock (slow_clock),
        .reset      (reset),
        .bus        (bus)
    );

    initial slow_clock = 1'b0;
    always #5 slow_clock = ~slow_clock;

    // Counts cycles in which store / reject were high entering an edge.
    always @(posedge slow_clock) begin
        if (bus.store === 1'b1)  store_cnt  = store_cnt + 1;
        if (bus.reject === 1'b1) reject_cnt = reject_cnt + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge slow_clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        reset            = 1'b1;
        bus.button_raw   = 1'b0;
        bus.switches_raw = 8'h00;
        #3;
        check("rst_store",  {31'd0, bus.store},  32'd0);
        check("rst_busy",   {31'd0, bus.busy},   32'd0);
        check("rst_reject", {31'd0, bus.reject}, 32'd0);
        check("rst_seq",    {24'd0, bus.sequence_word}, 32'd0);
        tick(3);
        reset = 1'b0;
        tick(2);

        // 1: clean press of 8'hA5, button held 40 cycles
        bus.switches_raw = 8'hA5;
        bus.button_raw   = 1'b1;
        store_snap       = store_cnt;
        tick(6);
        check("t1_store_e6", {31'd0, bus.store}, 32'd0);
        tick(1);
        check("t1_store_e7", {31'd0, bus.store}, 32'd1);
        check("t1_seq",      {24'd0, bus.sequence_word}, 32'hA5);
        check("t1_busy",     {31'd0, bus.busy}, 32'd1);
        tick(11);
        check("t1_store_e18", {31'd0, bus.store}, 32'd1);
        tick(1);
        check("t1_store_e19", {31'd0, bus.store}, 32'd0);
        check("t1_busy_rel",  {31'd0, bus.busy},  32'd1);
        tick(21);
        bus.button_raw = 1'b0;
        tick(10);
        check("t1_idle",     {31'd0, bus.busy}, 32'd0);
        check("t1_store_len", store_cnt - store_snap, 32'd12);
        check("t1_seq_kept", {24'd0, bus.sequence_word}, 32'hA5);

        // 2: 1-cycle bounces never produce a press
        store_snap  = store_cnt;
        reject_snap = reject_cnt;
        bus.button_raw = 1'b1; tick(1);
        bus.button_raw = 1'b0; tick(1);
        bus.button_raw = 1'b1; tick(1);
        bus.button_raw = 1'b0;
        tick(3);
        check("t2_busy_mid", {31'd0, bus.busy}, 32'd0);
        tick(12);
        check("t2_busy",   {31'd0, bus.busy}, 32'd0);
        check("t2_store",  store_cnt - store_snap, 32'd0);
        check("t2_reject", reject_cnt - reject_snap, 32'd0);

        // 3: zero value is rejected with a single pulse
        reject_snap      = reject_cnt;
        store_snap       = store_cnt;
        bus.switches_raw = 8'h00;
        bus.button_raw   = 1'b1;
        tick(7);
        check("t3_reject_e7", {31'd0, bus.reject}, 32'd1);
        check("t3_store_e7",  {31'd0, bus.store},  32'd0);
        check("t3_busy_e7",   {31'd0, bus.busy},   32'd1);
        check("t3_seq",       {24'd0, bus.sequence_word}, 32'hA5);
        tick(1);
        check("t3_reject_e8", {31'd0, bus.reject}, 32'd0);
        check("t3_busy_e8",   {31'd0, bus.busy},   32'd1);
        bus.button_raw = 1'b0;
        tick(10);
        check("t3_idle",       {31'd0, bus.busy}, 32'd0);
        check("t3_reject_cnt", reject_cnt - reject_snap, 32'd1);
        check("t3_store_cnt",  store_cnt - store_snap, 32'd0);

        // 4: switches change and a second press arrives during HOLD
        store_snap       = store_cnt;
        bus.switches_raw = 8'h3C;
        bus.button_raw   = 1'b1;
        tick(7);
        check("t4_store_e7", {31'd0, bus.store}, 32'd1);
        check("t4_seq_e7",   {24'd0, bus.sequence_word}, 32'h3C);
        bus.switches_raw = 8'hFF;
        bus.button_raw   = 1'b0;
        tick(5);
        bus.button_raw   = 1'b1;   // debounced high again at edge 18
        tick(6);
        check("t4_store_e18", {31'd0, bus.store}, 32'd1);
        tick(1);
        check("t4_store_e19", {31'd0, bus.store}, 32'd0);
        check("t4_seq_e19",   {24'd0, bus.sequence_word}, 32'h3C);
        tick(10);
        check("t4_store_len", store_cnt - store_snap, 32'd12);
        check("t4_busy_held", {31'd0, bus.busy}, 32'd1);
        bus.button_raw = 1'b0;
        tick(10);
        check("t4_idle",     {31'd0, bus.busy}, 32'd0);
        check("t4_seq_kept", {24'd0, bus.sequence_word}, 32'h3C);

        // 5: reset in the 5th hold cycle, then a normal press of 8'h11
        bus.switches_raw = 8'h55;
        bus.button_raw   = 1'b1;
        tick(7);
        check("t5_store_e7", {31'd0, bus.store}, 32'd1);
        tick(4);
        reset          = 1'b1;
        bus.button_raw = 1'b0;
        #1;
        check("t5_rst_store", {31'd0, bus.store}, 32'd0);
        check("t5_rst_busy",  {31'd0, bus.busy},  32'd0);
        check("t5_rst_seq",   {24'd0, bus.sequence_word}, 32'd0);
        tick(2);
        reset = 1'b0;
        tick(2);
        store_snap       = store_cnt;
        bus.switches_raw = 8'h11;
        bus.button_raw   = 1'b1;
        tick(6);
        check("t5_store_e6", {31'd0, bus.store}, 32'd0);
        tick(1);
        check("t5_store_e7", {31'd0, bus.store}, 32'd1);
        check("t5_seq",      {24'd0, bus.sequence_word}, 32'h11);
        tick(12);
        check("t5_store_e19", {31'd0, bus.store}, 32'd0);
        check("t5_store_len", store_cnt - store_snap, 32'd12);
        bus.button_raw = 1'b0;
        tick(10);
        check("t5_idle", {31'd0, bus.busy}, 32'd0);

        // 6: long hold gives one window; release and press 8'h22 gives another
        store_snap       = store_cnt;
        reject_snap      = reject_cnt;
        bus.switches_raw = 8'h77;
        bus.button_raw   = 1'b1;
        tick(100);
        check("t6_store_len1", store_cnt - store_snap, 32'd12);
        check("t6_store_off",  {31'd0, bus.store}, 32'd0);
        check("t6_busy_held",  {31'd0, bus.busy},  32'd1);
        check("t6_seq1",       {24'd0, bus.sequence_word}, 32'h77);
        check("t6_reject",     reject_cnt - reject_snap, 32'd0);
        bus.button_raw = 1'b0;
        tick(10);
        check("t6_idle1", {31'd0, bus.busy}, 32'd0);
        store_snap       = store_cnt;
        bus.switches_raw = 8'h22;
        bus.button_raw   = 1'b1;
        tick(7);
        check("t6_store_e7", {31'd0, bus.store}, 32'd1);
        check("t6_seq2",     {24'd0, bus.sequence_word}, 32'h22);
        tick(12);
        check("t6_store_e19",  {31'd0, bus.store}, 32'd0);
        check("t6_store_len2", store_cnt - store_snap, 32'd12);
        bus.button_raw = 1'b0;
        tick(10);
        check("t6_idle2",     {31'd0, bus.busy}, 32'd0);
        check("total_reject", reject_cnt, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
